// File: rtl/regfile.sv
// 32 x 64-bit LEGv8 register file, XZR hardwired, write-first bypass,
// plus a load scoreboard for read-after-write stall detection.
//
// Ports:
//   clk, rst_n         rising-edge clock, async active-low reset
//   rreg1/rdata1/busy1 read port 1 (prior value for MOVK), combinational
//   rreg2/rdata2/busy2 read port 2 (second ALU operand), combinational
//   wen/wreg/wdata     single writeback port
//   issue/issuereg     load entering the pipe marks its destination pending
//   flush              squash: clears every pending bit
//   pending            scoreboard vector, top bit (XZR) always 0
module regfile #(
    parameter int WORDSIZE = 64,
    parameter int REGSIZE  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [REGSIZE-1:0]      rreg1,
    input  logic [REGSIZE-1:0]      rreg2,
    output logic [WORDSIZE-1:0]     rdata1,
    output logic [WORDSIZE-1:0]     rdata2,
    output logic                    busy1,
    output logic                    busy2,
    input  logic                    wen,
    input  logic [REGSIZE-1:0]      wreg,
    input  logic [WORDSIZE-1:0]     wdata,
    input  logic                    issue,
    input  logic [REGSIZE-1:0]      issuereg,
    input  logic                    flush,
    output logic [2**REGSIZE-1:0]   pending
);

    localparam int NREG = 2**REGSIZE;
    localparam logic [REGSIZE-1:0] XZR = REGSIZE'(NREG - 1);

    // Only X0..X30 have storage; XZR reads are forced to zero below.
    logic [WORDSIZE-1:0] regs [NREG-1];
    logic [NREG-1:0]     pending_nxt;

    logic hit1;
    logic hit2;

    assign hit1 = wen && (wreg == rreg1);
    assign hit2 = wen && (wreg == rreg2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG - 1; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && (wreg != XZR)) begin
            regs[wreg] <= wdata;
        end
    end

    // Priority: flush > new issue > writeback clear > hold.
    // A same-cycle issue wins over the write so a fresh producer is tracked.
    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < NREG - 1; i++) begin
            if (flush) begin
                pending_nxt[i] = 1'b0;
            end else if (issue && (issuereg == REGSIZE'(i))) begin
                pending_nxt[i] = 1'b1;
            end else if (wen && (wreg == REGSIZE'(i))) begin
                pending_nxt[i] = 1'b0;
            end
        end
        pending_nxt[NREG-1] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign rdata1 = (rreg1 == XZR) ? '0 :
                    hit1           ? wdata :
                                     regs[rreg1];

    assign rdata2 = (rreg2 == XZR) ? '0 :
                    hit2           ? wdata :
                                     regs[rreg2];

    // A writeback landing this cycle resolves the hazard through the bypass.
    assign busy1 = (rreg1 != XZR) & pending[rreg1] & ~hit1;
    assign busy2 = (rreg2 != XZR) & pending[rreg2] & ~hit2;

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32-entry x 64-bit LEGv8 register file with a load scoreboard. Sits between decode and execute.
- Read port 1 supplies the prior register value that the wide-move unit consumes as its readreg input for MOVK.
- Read port 2 supplies the second ALU operand.
- Accepts writeback results, including the wide-move result, on one write port.
- Tracks registers with an outstanding load so decode can stall on read-after-write hazards.

Parameters:
- WORDSIZE, 64: data word width.
- REGSIZE, 5: register index width. Index 2**REGSIZE-1 (31) is XZR.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rreg1  input  REGSIZE  read port 1 index.
- rreg2  input  REGSIZE  read port 2 index.
- rdata1  output  WORDSIZE  read port 1 data, combinational.
- rdata2  output  WORDSIZE  read port 2 data, combinational.
- busy1  output  1  rreg1 has a pending load not resolved this cycle.
- busy2  output  1  rreg2 has a pending load not resolved this cycle.
- wen  input  1  write enable.
- wreg  input  REGSIZE  write index.
- wdata  input  WORDSIZE  write data.
- issue  input  1  a load targeting issuereg enters the pipe this cycle.
- issuereg  input  REGSIZE  destination of the issued load.
- flush  input  1  pipeline squash; clears all pending bits.
- pending  output  2**REGSIZE  scoreboard vector; bit 31 is always 0.

Behaviour:
- Reset (rst_n low, asynchronous): all 31 general registers are 0 and pending is 0. Outputs follow combinationally: rdata 0, busy 0. Reset mid-write discards the write.
- Storage: X0..X30 only. No flop exists for X31.
- Read, combinational, per port N:
  - rregN==31: rdataN=0.
  - else if wen and wreg==rregN: rdataN=wdata (write-first bypass, same cycle).
  - else: rdataN=reg[rregN].
- Write: on rising clk with wen=1 and wreg!=31, reg[wreg]<=wdata. Writes to 31 are discarded.
- Scoreboard next-state per bit i (i!=31), priority high to low:
  1. flush: 0.
  2. issue and issuereg==i: 1. A new producer overrides a same-cycle write that clears the bit.
  3. wen and wreg==i: 0.
  4. otherwise hold.
- issue or flush with issuereg/wreg==31 has no effect on bit 31.
- busyN = (rregN!=31) & pending[rregN] & ~(wen & wreg==rregN). A same-cycle writeback resolves the hazard via the bypass.
- busy depends only on current pending/write inputs, not on same-cycle issue. A register issued this cycle reads as busy from the next cycle.
- Both read ports may name the same register; both see identical data and busy.
- Latency: read 0 cycles; write visible without bypass from the cycle after the edge; scoreboard update takes 1 edge.
- No handshake back-pressure. Stalling on busy is the caller's responsibility. wen and issue are accepted every cycle.

Test Plan:
- Reset then read: hold rst_n low mid-cycle with wen=1, wreg=3, wdata=5. Release, read rreg1=3 -> rdata1=0, pending=0. Assert rst_n low asynchronously -> rdata1 returns 0 immediately without a clock edge.
- Write/bypass/XZR:
  - wen=1, wreg=7, wdata=0x1234_0000_0000_ABCD with rreg1=7 in the same cycle -> rdata1=0x1234_0000_0000_ABCD before the edge. After the edge with wen=0 -> same value.
  - wen=1, wreg=31, wdata=0xFFFF_FFFF_FFFF_FFFF, rreg2=31 -> rdata2=0, before and after the edge.
- Scoreboard set/clear:
  - issue=1, issuereg=9 -> next cycle pending[9]=1. With rreg1=9 -> busy1=1.
  - Next cycle wen=1, wreg=9, wdata=0x42 -> busy1=0 and rdata1=0x42 that cycle; pending[9]=0 after the edge.
- Simultaneous issue and write to the same register: pending[4]=1, then issue=1, issuereg=4 with wen=1, wreg=4, wdata=0x10 -> that cycle busy=0 and rdata=0x10; after the edge pending[4]=1 and reg[4]=0x10.
- Flush priority: pending bits 2 and 5 set; flush=1 with issue=1, issuereg=6 -> after the edge pending=0.
- MOVK-style read-modify-write chain, each write bypassed to rreg1 of the next instruction:
  - wreg=1, wdata=0x0000_0000_0000_BEEF, then wreg=1, wdata=0x0000_0000_CAFE_BEEF.
  - rreg1=1 each cycle -> 0x0000_0000_0000_BEEF, then 0x0000_0000_CAFE_BEEF, with no stall (busy1=0 throughout).
